// File: rtl/regfile_port_arbiter.sv
// regfile_port_arbiter
// Shares the single port of a register file (posedge read, negedge write)
// between NREQ requesters. One valid/ready transfer is granted per cycle in
// round-robin order; the register-file address/data/enable lines are driven
// from registers. Each accepted transaction gets a one-cycle rsp_valid pulse
// back to its issuer two edges after acceptance. Reads carry rsp_rdata;
// writes return rsp_rdata=0.
//
// Ports:
//   clk, rst_n    clock, asynchronous active-low reset
//   req_valid     per-requester request valid
//   req_ready     per-requester grant (at most one bit high)
//   req_write     per-requester 1=write, 0=read
//   req_addr      flattened addresses, requester i at [i*ADDR_W +: ADDR_W]
//   req_wdata     flattened write data, requester i at [i*DATA_W +: DATA_W]
//   req_lock      (RF_ARB_LOCK_EN only) lock request accompanying a transfer
//   rsp_valid     one-cycle completion pulse to the issuing requester
//   rsp_rdata     read data, valid only with rsp_valid
//   rf_address    register-file address
//   rf_data_in    register-file write data
//   rf_enable     register-file write enable
//   rf_data_out   register-file read data (registered inside the file)
//
// Optional feature macro: RF_ARB_LOCK_EN
//   Adds req_lock. A transfer with req_lock set locks arbitration to that
//   requester until it completes a transfer with req_lock clear, which
//   allows atomic read-modify-write sequences.

module regfile_port_arbiter #(
  parameter int NREQ   = 2,
  parameter int ADDR_W = 5,
  parameter int DATA_W = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NREQ-1:0]          req_valid,
  output logic [NREQ-1:0]          req_ready,
  input  logic [NREQ-1:0]          req_write,
  input  logic [NREQ*ADDR_W-1:0]   req_addr,
  input  logic [NREQ*DATA_W-1:0]   req_wdata,
`ifdef RF_ARB_LOCK_EN
  input  logic [NREQ-1:0]          req_lock,
`endif
  output logic [NREQ-1:0]          rsp_valid,
  output logic [DATA_W-1:0]        rsp_rdata,
  output logic [ADDR_W-1:0]        rf_address,
  output logic [DATA_W-1:0]        rf_data_in,
  output logic                     rf_enable,
  input  logic [DATA_W-1:0]        rf_data_out
);

  localparam int ID_W = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [ID_W-1:0] LAST_RST = ID_W'(NREQ - 1);

  logic [ID_W-1:0]   last_q;
  logic [NREQ-1:0]   eligible;

  logic              gnt_any;
  logic [ID_W-1:0]   gnt_id;
  logic              sel_write;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  logic              sel_lock;

  // Stage 1: transaction whose address is on rf_address this cycle.
  // Stage 2: transaction whose read data is on rf_data_out this cycle.
  logic              s1_v, s1_wr;
  logic [ID_W-1:0]   s1_id;
  logic              s2_v, s2_wr;
  logic [ID_W-1:0]   s2_id;

`ifdef RF_ARB_LOCK_EN
  logic              locked_q;
  logic [ID_W-1:0]   owner_q;

  always_comb begin
    eligible = '1;
    if (locked_q) begin
      eligible          = '0;
      eligible[owner_q] = 1'b1;
    end
  end
`else
  assign eligible = '1;
`endif

  // Round-robin scan starting just after the last winner. The selected
  // address/data/write are muxed here too, but only req_valid, last_q and
  // the lock state influence req_ready.
  always_comb begin : arb
    int idx;
    idx       = 0;
    req_ready = '0;
    gnt_any   = 1'b0;
    gnt_id    = '0;
    sel_write = 1'b0;
    sel_addr  = '0;
    sel_wdata = '0;
    sel_lock  = 1'b0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = int'(last_q) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!gnt_any && req_valid[idx] && eligible[idx]) begin
        gnt_any        = 1'b1;
        gnt_id         = ID_W'(idx);
        req_ready[idx] = 1'b1;
        sel_write      = req_write[idx];
        sel_addr       = req_addr[idx*ADDR_W +: ADDR_W];
        sel_wdata      = req_wdata[idx*DATA_W +: DATA_W];
`ifdef RF_ARB_LOCK_EN
        sel_lock       = req_lock[idx];
`endif
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_q     <= LAST_RST;
      rf_address <= '0;
      rf_data_in <= '0;
      rf_enable  <= 1'b0;
      s1_v       <= 1'b0;
      s1_wr      <= 1'b0;
      s1_id      <= '0;
      s2_v       <= 1'b0;
      s2_wr      <= 1'b0;
      s2_id      <= '0;
    end else begin
      if (gnt_any) begin
        last_q     <= gnt_id;
        rf_address <= sel_addr;
        rf_data_in <= sel_wdata;
        rf_enable  <= sel_write;
        s1_v       <= 1'b1;
        s1_wr      <= sel_write;
        s1_id      <= gnt_id;
      end else begin
        // Address and data hold; only the strobe and tag drop.
        rf_enable  <= 1'b0;
        s1_v       <= 1'b0;
      end
      s2_v  <= s1_v;
      s2_wr <= s1_wr;
      s2_id <= s1_id;
    end
  end

`ifdef RF_ARB_LOCK_EN
  // While locked only the owner can win, so every granted transfer simply
  // reloads the lock from its own req_lock bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      locked_q <= 1'b0;
      owner_q  <= '0;
    end else if (gnt_any) begin
      locked_q <= sel_lock;
      owner_q  <= gnt_id;
    end
  end
`else
  logic unused_lock;
  assign unused_lock = sel_lock;
`endif

  always_comb begin
    rsp_valid = '0;
    rsp_rdata = '0;
    if (s2_v) begin
      rsp_valid[s2_id] = 1'b1;
      if (!s2_wr) rsp_rdata = rf_data_out;
    end
  end

endmodule

// File: tb/tb_regfile_port_arbiter.sv
// Directed bench for regfile_port_arbiter with NREQ=3 and a behavioural
// register file (negedge write, registered posedge read).

module tb_regfile_port_arbiter;

  localparam int NREQ = 3;
  localparam int AW   = 5;
  localparam int DW   = 8;

  logic                 clk;
  logic                 rst_n;
  logic [NREQ-1:0]      req_valid;
  logic [NREQ-1:0]      req_ready;
  logic [NREQ-1:0]      req_write;
  logic [NREQ*AW-1:0]   req_addr;
  logic [NREQ*DW-1:0]   req_wdata;
`ifdef RF_ARB_LOCK_EN
  logic [NREQ-1:0]      req_lock;
`endif
  logic [NREQ-1:0]      rsp_valid;
  logic [DW-1:0]        rsp_rdata;
  logic [AW-1:0]        rf_address;
  logic [DW-1:0]        rf_data_in;
  logic                 rf_enable;
  logic [DW-1:0]        rf_data_out;

  logic [DW-1:0]        mem [32];

  int n_tests = 0;
  int n_fail  = 0;

  regfile_port_arbiter #(.NREQ(NREQ), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_write  (req_write),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
`ifdef RF_ARB_LOCK_EN
    .req_lock   (req_lock),
`endif
    .rsp_valid  (rsp_valid),
    .rsp_rdata  (rsp_rdata),
    .rf_address (rf_address),
    .rf_data_in (rf_data_in),
    .rf_enable  (rf_enable),
    .rf_data_out(rf_data_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Register-file model
  always @(negedge clk) if (rf_enable) mem[rf_address] <= rf_data_in;
  always @(posedge clk) rf_data_out <= mem[rf_address];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic set_req(input int i, input logic v, input logic w,
                         input logic [AW-1:0] a, input logic [DW-1:0] d);
    req_valid[i]          = v;
    req_write[i]          = w;
    req_addr[i*AW +: AW]  = a;
    req_wdata[i*DW +: DW] = d;
  endtask

  task automatic clear_reqs();
    req_valid = '0;
    req_write = '0;
    req_addr  = '0;
    req_wdata = '0;
  endtask

  task automatic to_neg();
    @(negedge clk);
  endtask

  task automatic to_pos();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  logic [NREQ-1:0] exp_gnt [3];

  initial begin
    exp_gnt[0] = 3'b001;
    exp_gnt[1] = 3'b010;
    exp_gnt[2] = 3'b100;
    for (int i = 0; i < 32; i++) mem[i] = 8'h10 + 8'(i);
    mem[31] = 8'h3C;
    rf_data_out = '0;
    rst_n = 1'b0;
    clear_reqs();
`ifdef RF_ARB_LOCK_EN
    req_lock = '0;
`endif

    // Reset state
    to_pos();
    to_neg();
    chk("rst_ready", req_ready, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_rdata", rsp_rdata, 0);
    chk("rst_rf_address", rf_address, 0);
    chk("rst_rf_data_in", rf_data_in, 0);
    chk("rst_rf_enable", rf_enable, 0);
    to_pos();
    rst_n = 1'b1;
    set_req(0, 1, 0, 0, 0);
    set_req(1, 1, 0, 1, 0);
    to_neg();
    chk("first_grant", req_ready, 3'b001);
    clear_reqs();
    to_pos();

    // Write A5 to address 3, then read it back from the next cycle
    set_req(0, 1, 1, 5'd3, 8'hA5);
    to_neg();
    chk("wr_ready", req_ready, 3'b001);
    to_pos();
    set_req(0, 1, 0, 5'd3, 8'h00);
    to_neg();
    chk("rd_ready", req_ready, 3'b001);
    chk("wr_rf_enable", rf_enable, 1);
    chk("wr_rf_address", rf_address, 3);
    chk("wr_rf_data_in", rf_data_in, 8'hA5);
    chk("wr_rsp_early", rsp_valid, 0);
    to_pos();
    clear_reqs();
    to_neg();
    chk("wr_ack_valid", rsp_valid, 3'b001);
    chk("wr_ack_rdata", rsp_rdata, 0);
    chk("rd_rf_enable", rf_enable, 0);
    to_pos();
    to_neg();
    chk("raw_valid", rsp_valid, 3'b001);
    chk("raw_rdata", rsp_rdata, 8'hA5);
    to_pos();
    to_neg();
    chk("raw_done", rsp_valid, 0);
    to_pos();

    // Single read of address 31 with idle cycles around it
    set_req(2, 1, 0, 5'd31, 8'h00);
    to_neg();
    chk("idle_ready", req_ready, 3'b100);
    to_pos();
    clear_reqs();
    for (int c = 0; c < 5; c++) begin
      to_neg();
      chk("idle_rf_enable", rf_enable, 0);
      chk("idle_rsp_valid", rsp_valid, (c == 1) ? 3'b100 : 3'b000);
      if (c == 1) chk("idle_rdata", rsp_rdata, 8'h3C);
      to_pos();
    end

    // Three-way contention, six reads; requester i reads address 8+i
    for (int c = 0; c < 8; c++) begin
      if (c < 6) begin
        for (int i = 0; i < NREQ; i++) set_req(i, 1, 0, 5'(8 + i), 8'h00);
      end else begin
        clear_reqs();
      end
      to_neg();
      if (c < 6) chk("cont_grant", req_ready, exp_gnt[c % 3]);
      if (c >= 2) begin
        chk("cont_rsp_valid", rsp_valid, exp_gnt[(c - 2) % 3]);
        chk("cont_rdata", rsp_rdata, 8'h18 + 8'((c - 2) % 3));
      end else begin
        chk("cont_rsp_idle", rsp_valid, 0);
      end
      to_pos();
    end

    // Reset between E0 and E1 of a read
    set_req(0, 1, 0, 5'd5, 8'h00);
    to_neg();
    chk("mid_ready", req_ready, 3'b001);
    @(posedge clk);
    #1;
    clear_reqs();
    #1;
    rst_n = 1'b0;
    #1;
    chk("mid_rf_address", rf_address, 0);
    chk("mid_rf_enable", rf_enable, 0);
    #1;
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      to_neg();
      chk("mid_no_rsp", rsp_valid, 0);
      to_pos();
    end
    set_req(1, 1, 0, 5'd6, 8'h00);
    to_neg();
    chk("restart_ready", req_ready, 3'b010);
    to_pos();
    clear_reqs();
    to_neg();
    chk("restart_rsp_early", rsp_valid, 0);
    to_pos();
    to_neg();
    chk("restart_rsp_valid", rsp_valid, 3'b010);
    chk("restart_rdata", rsp_rdata, 8'h16);
    to_pos();

`ifdef RF_ARB_LOCK_EN
    // Locked read then unlocking write by requester 1; requester 0 waits
    req_lock = 3'b010;
    set_req(1, 1, 0, 5'd7, 8'h00);
    to_neg();
    chk("lock_rd_ready", req_ready, 3'b010);
    to_pos();
    req_lock = '0;
    set_req(1, 1, 1, 5'd7, 8'h5A);
    set_req(0, 1, 0, 5'd7, 8'h00);
    to_neg();
    chk("lock_hold_ready", req_ready, 3'b010);
    to_pos();
    set_req(1, 0, 0, 5'd0, 8'h00);
    to_neg();
    chk("unlock_ready", req_ready, 3'b001);
    chk("lock_rd_rsp", rsp_valid, 3'b010);
    chk("lock_rd_rdata", rsp_rdata, 8'h17);
    to_pos();
    clear_reqs();
    to_neg();
    chk("lock_wr_ack", rsp_valid, 3'b010);
    chk("lock_wr_rdata", rsp_rdata, 0);
    to_pos();
    to_neg();
    chk("after_lock_rsp", rsp_valid, 3'b001);
    chk("after_lock_rdata", rsp_rdata, 8'h5A);
    to_pos();
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/regfile_port_arbiter.md
Name: regfile_port_arbiter

Overview:
- Shares the single port of the 32x8 register file between NREQ requesters (e.g. decode/execute, debug loader, DMA).
- The register file reads on posedge and writes on negedge. This block accepts read and write requests through valid/ready handshakes and grants one per cycle, round-robin.
- It drives the register-file address, data and enable lines from registers, and returns a one-cycle response pulse to the requester that issued each transaction.

Parameters:
- NREQ, 2, number of requesters (2..4)
- ADDR_W, 5, register-file address width
- DATA_W, 8, register-file data width

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset
- req_valid  in  NREQ  per-requester request valid
- req_ready  out  NREQ  per-requester grant; at most one bit high
- req_write  in  NREQ  per-requester 1=write, 0=read
- req_addr  in  NREQ*ADDR_W  flattened addresses; requester i is at [i*ADDR_W +: ADDR_W]
- req_wdata  in  NREQ*DATA_W  flattened write data; requester i is at [i*DATA_W +: DATA_W]
- rsp_valid  out  NREQ  one-cycle completion pulse to the issuing requester
- rsp_rdata  out  DATA_W  read data, valid only with rsp_valid
- rf_address  out  ADDR_W  register-file address
- rf_data_in  out  DATA_W  register-file write data
- rf_enable  out  1  register-file write enable
- rf_data_out  in  DATA_W  register-file read data

Interface: one clock; reset is asynchronous and active-low (clk, rst_n).

Behaviour:
- Reset values: req_ready=0, rsp_valid=0, rsp_rdata=0, rf_address=0, rf_data_in=0, rf_enable=0. Round-robin pointer last=NREQ-1, so requester 0 wins first.
- Arbitration (combinational):
  - Scan req_valid starting at last+1, with modulo-NREQ wrap.
  - The first valid requester gets req_ready high. req_ready never depends on req_wdata or req_addr.
- A transfer occurs at a posedge where req_valid[i] and req_ready[i] are both high (edge E0). At E0:
  - last <= i.
  - rf_address <= addr_i; rf_data_in <= wdata_i; rf_enable <= write_i.
  - Stage-1 tag <= {id=i, write=write_i, v=1}.
- No transfer at a posedge: rf_enable <= 0 and stage-1 v <= 0. rf_address and rf_data_in hold their values.
- Cycle E0..E1:
  - For a write, the register file writes on the intervening negedge.
  - At E1 the register file latches rf_data_out from rf_address. Stage-2 tag <= stage-1 tag.
- Cycle E1..E2:
  - rsp_valid[id] = stage-2 v.
  - rsp_rdata = rf_data_out if the transaction is a read, otherwise 0.
  - Read latency: data is presented 2 edges after acceptance. Writes receive the same ack timing.
- Throughput: one transaction per cycle, fully pipelined. The response path has no backpressure; requesters must always accept rsp_valid.
- Read-after-write:
  - A write accepted at E0 followed by a read of the same address at E1 returns the new data, because the negedge write precedes the E2 latch.
  - Same-cycle conflicts cannot occur because only one request is granted per cycle.
- A requester may hold req_valid high across several grants. It is re-granted only after the other valid requesters have been served.
- Reset asserted mid-operation:
  - All outputs and tags clear immediately and in-flight responses are dropped.
  - rf_enable falls asynchronously, so a pending write may or may not have committed; requesters must reissue it.
- Address and data widths pass through unchanged. No arithmetic is performed.

Optional Feature:
- Macro: RF_ARB_LOCK_EN.
- When defined:
  - Adds input req_lock[NREQ].
  - A transfer with req_lock[i]=1 sets lock_owner=i and locked=1.
  - While locked, only lock_owner can be granted and others see req_ready=0.
  - A transfer by lock_owner with req_lock=0 clears locked after that transfer, which enables atomic read-modify-write.
  - Reset clears locked.
- When undefined: the req_lock port is absent and arbitration is pure round-robin.

Test Plan:
- Reset: hold rst_n=0, then release. All outputs must be 0, and the first grant goes to requester 0 when requesters 0 and 1 request together.
- Write then read: requester 0 writes 8'hA5 to address 3 at E0 and reads address 3 at E1. rsp_valid[0] must pulse at E1..E2 (write ack) and at E2..E3 with rsp_rdata=8'hA5.
- Contention: NREQ=3, all three hold valid and issue 6 reads. Grant order must be 0,1,2,0,1,2, and each rsp_valid pulse must be tagged to the correct requester 2 edges after its grant.
- Idle gaps: a single read of address 31 preloaded with 8'h3C returns 8'h3C. rf_enable must stay 0 in every cycle without a write grant.
- Reset mid-operation: assert rst_n low between E0 and E1 of a read. rsp_valid must never pulse for that read, and the pipeline must restart cleanly afterwards.
- With RF_ARB_LOCK_EN defined: requester 1 performs a locked read of address 7, then an unlocked write of address 7. Requester 0 stays valid throughout but is not granted until after the unlocking write.
